// File: rtl/mem_bus_sequencer.sv
// Multi-cycle instruction sequencer owning the shared memory bus of the TSC CPU.
// Optional handshake timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_bus_sequencer #(
    parameter int WORD_SIZE      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] data_addr,
    input  logic [WORD_SIZE-1:0] store_data,
    input  logic                 is_load,
    input  logic                 is_store,
    input  logic                 is_wwd,
    input  logic                 is_halt,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] mdr,
    output logic                 pc_write,
    output logic                 reg_write_en,
    output logic                 wwd_strobe,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic                 halted,
    output logic [2:0]           state,
    output logic                 timeout_err
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic                   read_d, write_d;
    logic [WORD_SIZE-1:0]   addr_d;
    logic [WORD_SIZE-1:0]   wr_data;
    logic                   load_instr, load_mdr, load_wdata, count_inst;
    logic                   timeout_fire;

    assign state = state_q;
    assign data  = writeM ? wr_data : {WORD_SIZE{1'bz}};

    assign pc_write     = (state_q == WB);
    assign reg_write_en = (state_q == WB) && !is_store && !is_wwd;
    assign wwd_strobe   = (state_q == WB) && is_wwd;
    assign halted       = (state_q == HALT);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Fires only on an edge where the open request still has no response.
    assign timeout_hit  = (readM || writeM) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_fire = timeout_hit && !(readM && inputReady) && !(writeM && ackOutput);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (timeout_fire)
                timeout_err <= 1'b1;
            if ((readM || writeM) && (read_d || write_d))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end
`else
    assign timeout_fire = 1'b0;
    // Comparison is always false; it keeps TIMEOUT_CYCLES referenced in this build.
    assign timeout_err  = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d    = state_q;
        read_d     = readM;
        write_d    = writeM;
        addr_d     = address;
        load_instr = 1'b0;
        load_mdr   = 1'b0;
        load_wdata = 1'b0;
        count_inst = 1'b0;
        case (state_q)
            FETCH: begin
                if (!readM) begin
                    read_d = 1'b1;
                    addr_d = pc;
                end else if (inputReady) begin
                    load_instr = 1'b1;
                    read_d     = 1'b0;
                    state_d    = DECODE;
                end else if (timeout_fire) begin
                    read_d  = 1'b0;
                    state_d = HALT;
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (is_halt) begin
                    count_inst = 1'b1;
                    state_d    = HALT;
                end else if (is_load) begin
                    read_d  = 1'b1;
                    addr_d  = data_addr;
                    state_d = MEM_RD;
                end else if (is_store) begin
                    write_d    = 1'b1;
                    addr_d     = data_addr;
                    load_wdata = 1'b1;
                    state_d    = MEM_WR;
                end else begin
                    state_d = WB;
                end
            end
            MEM_RD: begin
                if (inputReady) begin
                    load_mdr = 1'b1;
                    read_d   = 1'b0;
                    state_d  = WB;
                end else if (timeout_fire) begin
                    read_d  = 1'b0;
                    state_d = HALT;
                end
            end
            MEM_WR: begin
                if (ackOutput) begin
                    write_d = 1'b0;
                    state_d = WB;
                end else if (timeout_fire) begin
                    write_d = 1'b0;
                    state_d = HALT;
                end
            end
            WB: begin
                // pc is expected to already hold the next fetch address here.
                count_inst = 1'b1;
                read_d     = 1'b1;
                addr_d     = pc;
                state_d    = FETCH;
            end
            HALT: state_d = HALT;
            default: begin
                read_d  = 1'b0;
                write_d = 1'b0;
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            readM    <= 1'b0;
            writeM   <= 1'b0;
            address  <= '0;
            instr    <= WORD_SIZE'(16'hF000);
            mdr      <= '0;
            wr_data  <= '0;
            num_inst <= '0;
        end else begin
            state_q <= state_d;
            readM   <= read_d;
            writeM  <= write_d;
            address <= addr_d;
            if (load_instr)
                instr <= data;
            if (load_mdr)
                mdr <= data;
            if (load_wdata)
                wr_data <= store_data;
            if (count_inst)
                num_inst <= num_inst + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed self-checking bench for mem_bus_sequencer; timeout checks run when MEM_TIMEOUT_EN is defined.
module tb_mem_bus_sequencer;

    logic        clk;
    logic        reset_n;
    logic [15:0] pc, data_addr, store_data;
    logic        is_load, is_store, is_wwd, is_halt;
    logic        inputReady, ackOutput;
    logic        readM, writeM;
    logic [15:0] address, instr, mdr, num_inst;
    logic        pc_write, reg_write_en, wwd_strobe, halted, timeout_err;
    logic [2:0]  state;
    wire  [15:0] data;
    logic        mem_drive;
    logic [15:0] mem_rd_data;

    int checks = 0;
    int errors = 0;

    assign data = mem_drive ? mem_rd_data : 16'hzzzz;

    mem_bus_sequencer #(.WORD_SIZE(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .data_addr(data_addr), .store_data(store_data),
        .is_load(is_load), .is_store(is_store), .is_wwd(is_wwd), .is_halt(is_halt),
        .inputReady(inputReady), .ackOutput(ackOutput), .readM(readM), .writeM(writeM),
        .address(address), .data(data), .instr(instr), .mdr(mdr), .pc_write(pc_write),
        .reg_write_en(reg_write_en), .wwd_strobe(wwd_strobe), .num_inst(num_inst),
        .halted(halted), .state(state), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] p, input logic [15:0] da, input logic [15:0] sd,
                                 input logic ld, input logic st, input logic ww, input logic ht);
        pc         = p;
        data_addr  = da;
        store_data = sd;
        is_load    = ld;
        is_store   = st;
        is_wwd     = ww;
        is_halt    = ht;
    endtask

    // Called in FETCH with readM high: memory answers on the next edge.
    task automatic fetchWith(input logic [15:0] word);
        inputReady  = 1'b1;
        mem_rd_data = word;
        mem_drive   = 1'b1;
        tick();
        inputReady = 1'b0;
        mem_drive  = 1'b0;
    endtask

    // Drives a probe pattern; it reads back intact only if the DUT has released the bus.
    task automatic probeBus(input string tag);
        mem_rd_data = 16'h5A5A;
        mem_drive   = 1'b1;
        #1;
        checkOutput(tag, data, 16'h5A5A);
        mem_drive = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        inputReady  = 1'b0;
        ackOutput   = 1'b0;
        mem_drive   = 1'b0;
        mem_rd_data = 16'h0000;
        applyStimulus(16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        $display("[TB] reset values");
        checkOutput("rst_state", 16'(state), 16'd0);
        checkOutput("rst_readM", 16'(readM), 16'd0);
        checkOutput("rst_writeM", 16'(writeM), 16'd0);
        checkOutput("rst_address", address, 16'h0000);
        checkOutput("rst_instr", instr, 16'hF000);
        checkOutput("rst_mdr", mdr, 16'h0000);
        checkOutput("rst_num_inst", num_inst, 16'h0000);
        checkOutput("rst_halted", 16'(halted), 16'd0);
        checkOutput("rst_enables", 16'({pc_write, reg_write_en, wwd_strobe}), 16'd0);
        checkOutput("rst_timeout_err", 16'(timeout_err), 16'd0);

        reset_n = 1'b1;
        tick();
        checkOutput("first_fetch_readM", 16'(readM), 16'd1);
        checkOutput("first_fetch_addr", address, 16'h0010);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_readM", 16'(readM), 16'd0);
        checkOutput("async_rst_addr", address, 16'h0000);
        probeBus("async_rst_data_released");
        #3;
        reset_n = 1'b1;
        tick();
        checkOutput("refetch_readM", 16'(readM), 16'd1);

        $display("[TB] ALU instruction");
        inputReady  = 1'b1;
        mem_rd_data = 16'h1000;
        mem_drive   = 1'b1;
        tick();
        mem_drive = 1'b0;
        checkOutput("alu_decode_state", 16'(state), 16'd1);
        checkOutput("alu_instr", instr, 16'h1000);
        checkOutput("alu_decode_readM", 16'(readM), 16'd0);
        tick();
        checkOutput("alu_exec_state", 16'(state), 16'd2);
        checkOutput("alu_exec_readM", 16'(readM), 16'd0);
        tick();
        checkOutput("alu_wb_state", 16'(state), 16'd5);
        checkOutput("alu_wb_pc_write", 16'(pc_write), 16'd1);
        checkOutput("alu_wb_reg_write", 16'(reg_write_en), 16'd1);
        checkOutput("alu_wb_wwd", 16'(wwd_strobe), 16'd0);
        tick();
        inputReady = 1'b0;
        checkOutput("alu_next_state", 16'(state), 16'd0);
        checkOutput("alu_num_inst", num_inst, 16'd1);
        checkOutput("alu_pc_write_drop", 16'(pc_write), 16'd0);
        checkOutput("alu_next_readM", 16'(readM), 16'd1);

        $display("[TB] LWD with 3 wait cycles");
        applyStimulus(16'h0010, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        fetchWith(16'h7000);
        checkOutput("lwd_decode_readM", 16'(readM), 16'd0);
        tick();
        checkOutput("lwd_exec_readM", 16'(readM), 16'd0);
        tick();
        checkOutput("lwd_memrd_state", 16'(state), 16'd3);
        checkOutput("lwd_memrd_readM", 16'(readM), 16'd1);
        checkOutput("lwd_memrd_addr", address, 16'h0040);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("lwd_wait_state", 16'(state), 16'd3);
        checkOutput("lwd_wait_readM", 16'(readM), 16'd1);
        inputReady  = 1'b1;
        mem_rd_data = 16'h1234;
        mem_drive   = 1'b1;
        tick();
        inputReady = 1'b0;
        mem_drive  = 1'b0;
        checkOutput("lwd_wb_state", 16'(state), 16'd5);
        checkOutput("lwd_mdr", mdr, 16'h1234);
        checkOutput("lwd_wb_reg_write", 16'(reg_write_en), 16'd1);
        checkOutput("lwd_wb_readM", 16'(readM), 16'd0);
        tick();
        checkOutput("lwd_num_inst", num_inst, 16'd2);

        $display("[TB] SWD with ack after 2 cycles");
        applyStimulus(16'h0010, 16'h0080, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        fetchWith(16'h9000);
        tick();
        tick();
        checkOutput("swd_memwr_state", 16'(state), 16'd4);
        checkOutput("swd_writeM", 16'(writeM), 16'd1);
        checkOutput("swd_readM", 16'(readM), 16'd0);
        checkOutput("swd_addr", address, 16'h0080);
        checkOutput("swd_data", data, 16'hBEEF);
        tick();
        tick();
        checkOutput("swd_wait_state", 16'(state), 16'd4);
        checkOutput("swd_wait_data", data, 16'hBEEF);
        ackOutput = 1'b1;
        tick();
        ackOutput = 1'b0;
        checkOutput("swd_wb_state", 16'(state), 16'd5);
        checkOutput("swd_wb_writeM", 16'(writeM), 16'd0);
        checkOutput("swd_wb_reg_write", 16'(reg_write_en), 16'd0);
        checkOutput("swd_wb_pc_write", 16'(pc_write), 16'd1);
        probeBus("swd_data_released");
        tick();
        checkOutput("swd_num_inst", num_inst, 16'd3);

        $display("[TB] WWD");
        applyStimulus(16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        fetchWith(16'hF01C);
        tick();
        tick();
        checkOutput("wwd_wb_strobe", 16'(wwd_strobe), 16'd1);
        checkOutput("wwd_wb_reg_write", 16'(reg_write_en), 16'd0);
        tick();
        checkOutput("wwd_strobe_drop", 16'(wwd_strobe), 16'd0);
        checkOutput("wwd_num_inst", num_inst, 16'd4);

        $display("[TB] num_inst wrap");
        applyStimulus(16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        fetchWith(16'h1000);
        tick();
        tick();
        force dut.num_inst = 16'hFFFF;
        #2;
        release dut.num_inst;
        tick();
        checkOutput("wrap_num_inst", num_inst, 16'h0000);

        $display("[TB] HLT");
        applyStimulus(16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        fetchWith(16'hF01D);
        tick();
        tick();
        checkOutput("hlt_state", 16'(state), 16'd6);
        checkOutput("hlt_halted", 16'(halted), 16'd1);
        checkOutput("hlt_num_inst", num_inst, 16'd1);
        checkOutput("hlt_bus_idle", 16'({readM, writeM}), 16'd0);
        inputReady = 1'b1;
        ackOutput  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        checkOutput("hlt_stays_state", 16'(state), 16'd6);
        checkOutput("hlt_stays_idle", 16'({readM, writeM}), 16'd0);
        checkOutput("hlt_pc_write", 16'(pc_write), 16'd0);
        checkOutput("hlt_timeout_err", 16'(timeout_err), 16'd0);

`ifdef MEM_TIMEOUT_EN
        $display("[TB] fetch timeout");
        reset_n = 1'b0;
        #1;
        checkOutput("to_rst_halted", 16'(halted), 16'd0);
        #1;
        reset_n = 1'b1;
        tick();
        checkOutput("to_fetch_readM", 16'(readM), 16'd1);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("to_wait3_state", 16'(state), 16'd0);
        checkOutput("to_wait3_err", 16'(timeout_err), 16'd0);
        tick();
        checkOutput("to_state", 16'(state), 16'd6);
        checkOutput("to_err", 16'(timeout_err), 16'd1);
        checkOutput("to_readM", 16'(readM), 16'd0);
        checkOutput("to_num_inst", num_inst, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
